// File: rtl/apb_int_master.sv
// APB requester: turns one valid/ready command into one APB transfer and one response.
// Optional PREADY timeout is compiled in with `define APB_INT_MASTER_TIMEOUT_EN.
module apb_int_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // state  | meaning
  // IDLE   | cmd_ready high, waiting for a command
  // SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
  // ACCESS | PSEL=1, PENABLE=1 until PREADY (or timeout)
  // RESP   | rsp_valid high until rsp_ready
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t                r_state;
  logic                  r_cmd_ready;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

`ifdef APB_INT_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_rsp_timeout;
  assign rsp_timeout = r_rsp_timeout;
`else
  localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b1;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
`ifdef APB_INT_MASTER_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_pwrite    <= cmd_write;
            r_paddr     <= cmd_addr;
            r_pwdata    <= cmd_wdata;
            r_cmd_ready <= 1'b0;
            r_psel      <= 1'b1;
            r_state     <= S_SETUP;
`ifdef APB_INT_MASTER_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // PSLVERR is only meaningful alongside PREADY; error responses carry no data
          if (PREADY) begin
            r_rsp_rdata   <= (!r_pwrite && !PSLVERR) ? PRDATA : '0;
            r_rsp_err     <= PSLVERR;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
`ifdef APB_INT_MASTER_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
          end else if (r_to_cnt == TO_LAST) begin
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_to_cnt      <= r_to_cnt + CNT_W'(1);
`endif
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_int_master.sv
// Directed bench for apb_int_master: inputs change and outputs are sampled on the falling edge.
// Honours `define APB_INT_MASTER_TIMEOUT_EN to select the timeout or stuck-slave scenario.
module tb_apb_int_master;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 PCLK = ~PCLK;

  apb_int_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) u_dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts at a falling edge with the DUT idle; returns one falling edge after the response handshake.
  task automatic run_xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int waits, input logic [DW-1:0] rd,
                          input logic err, input logic [DW-1:0] exp_rd, input int hold);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0; rsp_ready = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    check_val({tag, "_setup_psel"}, PSEL, 1);
    check_val({tag, "_setup_penable"}, PENABLE, 0);
    check_val({tag, "_setup_cmd_ready"}, cmd_ready, 0);
    check_val({tag, "_setup_paddr"}, PADDR, addr);
    check_val({tag, "_setup_pwrite"}, PWRITE, wr);
    check_val({tag, "_setup_pwdata"}, PWDATA, wd);
    @(negedge PCLK);
    for (int c = 0; c <= waits; c++) begin
      check_val({tag, "_access_psel"}, PSEL, 1);
      check_val({tag, "_access_penable"}, PENABLE, 1);
      check_val({tag, "_access_paddr"}, PADDR, addr);
      check_val({tag, "_access_rsp_valid"}, rsp_valid, 0);
      PREADY  = (c == waits);
      PSLVERR = (c == waits) ? err : 1'b1;
      PRDATA  = (c == waits) ? rd : 32'hDEAD_BEEF;
      @(negedge PCLK);
    end
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hFFFF_FFFF;
    check_val({tag, "_resp_valid"}, rsp_valid, 1);
    check_val({tag, "_resp_psel"}, PSEL, 0);
    check_val({tag, "_resp_penable"}, PENABLE, 0);
    check_val({tag, "_resp_rdata"}, rsp_rdata, exp_rd);
    check_val({tag, "_resp_err"}, rsp_err, err);
    check_val({tag, "_resp_timeout"}, rsp_timeout, 0);
    check_val({tag, "_resp_cmd_ready"}, cmd_ready, 0);
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0020; cmd_wdata = '0;
      @(negedge PCLK);
      check_val({tag, "_hold_valid"}, rsp_valid, 1);
      check_val({tag, "_hold_rdata"}, rsp_rdata, exp_rd);
      check_val({tag, "_hold_err"}, rsp_err, err);
      check_val({tag, "_hold_cmd_ready"}, cmd_ready, 0);
      check_val({tag, "_hold_psel"}, PSEL, 0);
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check_val({tag, "_done_valid"}, rsp_valid, 0);
    check_val({tag, "_done_cmd_ready"}, cmd_ready, 1);
    check_val({tag, "_done_psel"}, PSEL, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed simulation time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (2) @(negedge PCLK);
    check_val("rst_cmd_ready", cmd_ready, 1);
    check_val("rst_apb_ctrl", {PSEL, PENABLE, PWRITE}, 0);
    check_val("rst_paddr", PADDR, 0);
    check_val("rst_pwdata", PWDATA, 0);
    check_val("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 0);
    check_val("rst_rsp_rdata", rsp_rdata, 0);
    PRESET = 1'b0;
    @(negedge PCLK);
    check_val("post_rst_cmd_ready", cmd_ready, 1);
    check_val("post_rst_psel", PSEL, 0);

    run_xfer("wr4", 1'b1, 16'h0004, 32'h0000_0001, 0, 32'h1234_5678, 1'b0, 32'h0, 0);
    run_xfer("rd10", 1'b0, 16'h0010, 32'h0, 2, 32'h0000_0005, 1'b0, 32'h0000_0005, 0);
    run_xfer("rdfc_err", 1'b0, 16'h00FC, 32'h0, 0, 32'hBAD0_0001, 1'b1, 32'h0, 0);
    run_xfer("rd30_hold", 1'b0, 16'h0030, 32'h0, 1, 32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 3);
    run_xfer("rd20_pend", 1'b0, 16'h0020, 32'h0, 0, 32'h0000_00C3, 1'b0, 32'h0000_00C3, 0);

    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0040; cmd_wdata = '0;
    PREADY = 1'b0; rsp_ready = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
`ifdef APB_INT_MASTER_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      check_val("to_wait_psel", PSEL, 1);
      check_val("to_wait_penable", PENABLE, 1);
      check_val("to_wait_rsp_valid", rsp_valid, 0);
      @(negedge PCLK);
    end
    check_val("to_psel", PSEL, 0);
    check_val("to_penable", PENABLE, 0);
    check_val("to_rsp_valid", rsp_valid, 1);
    check_val("to_rsp_err", rsp_err, 1);
    check_val("to_rsp_timeout", rsp_timeout, 1);
    check_val("to_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check_val("to_done_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = 16'h0044;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    repeat (3) @(negedge PCLK);
`else
    repeat (100) @(negedge PCLK);
    check_val("stuck_psel", PSEL, 1);
    check_val("stuck_penable", PENABLE, 1);
    check_val("stuck_rsp_valid", rsp_valid, 0);
    check_val("stuck_rsp_timeout", rsp_timeout, 0);
`endif
    check_val("mid_access_penable", PENABLE, 1);
    #2 PRESET = 1'b1;
    #1;
    check_val("arst_psel", PSEL, 0);
    check_val("arst_penable", PENABLE, 0);
    check_val("arst_rsp_valid", rsp_valid, 0);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    check_val("arst_rel_cmd_ready", cmd_ready, 1);
    check_val("arst_rel_psel", PSEL, 0);
    check_val("arst_rel_rsp_valid", rsp_valid, 0);
    check_val("arst_rel_paddr", PADDR, 0);

    run_xfer("wr8_post", 1'b1, 16'h0008, 32'h0000_00AA, 1, 32'h0000_0077, 1'b0, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/apb_int_master.md
# apb_int_master

APB requester (initiator) that issues single read/write transfers onto the APB bus of the interrupt-counter peripheral on behalf of a simple valid/ready command port. It runs the SETUP/ACCESS phases, honours PREADY wait states, captures PRDATA/PSLVERR, and returns one response per command. An optional PREADY timeout recovers from a slave that stalls indefinitely. It sits between the firmware-side command source and the APB slave.

## Interface
- DATA_WIDTH, 32, width of PWDATA/PRDATA/cmd_wdata/rsp_rdata
- ADDR_WIDTH, 16, width of PADDR/cmd_addr
- TIMEOUT_CYCLES, 16, maximum consecutive ACCESS cycles with PREADY low (must be ≥1); only used when the timeout is compiled in
- PCLK  in  1  APB clock; all logic is rising-edge
- PRESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept; high only in IDLE
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes, errors and timeouts
- rsp_err  out  1  PSLVERR seen, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH
- PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1

## Operation
- States: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE: cmd_ready=1. When cmd_valid is high, latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Always go to ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1. A cycle with PREADY=1 completes the transfer:
  - capture PRDATA (reads only, else 0) into rsp_rdata;
  - rsp_err = PSLVERR; rsp_timeout = 0;
  - PSEL and PENABLE fall; go to RESP.
  - PREADY=0: stay in ACCESS with all APB outputs stable.
- PSLVERR is ignored when PREADY=0.
- RESP: rsp_valid=1 and response fields held stable. When rsp_ready is high, rsp_valid clears and the FSM returns to IDLE. The next command can be accepted no earlier than the following cycle.
- PADDR/PWRITE/PWDATA hold their last value between transfers.
- Back-to-back transfers are never issued: there is always at least one IDLE cycle between transfers.
- Reset: asynchronous. State goes to IDLE and every output goes to 0 except cmd_ready=1: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0. Reset during SETUP/ACCESS drops PSEL/PENABLE immediately; no response is generated for the aborted transfer.

## Timing
- Command accepted at edge T → SETUP at T+1, ACCESS at T+2.
- With zero wait states, rsp_valid=1 at T+3. Each PREADY-low ACCESS cycle adds one cycle.
- Minimum command-to-command spacing is 4 cycles (IDLE, SETUP, ACCESS, RESP) when rsp_ready is held high.
- Timeout counter: counts ACCESS cycles with PREADY=0 and clears on entry to SETUP. Width is $clog2(TIMEOUT_CYCLES+1).

## Configuration
- APB_INT_MASTER_TIMEOUT_EN defined:
  - In the TIMEOUT_CYCLES-th consecutive ACCESS cycle with PREADY=0, the transfer aborts at the end of that cycle.
  - PSEL/PENABLE fall and the FSM goes to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - A PREADY=1 in that same cycle takes priority and completes normally.
- Not defined: no counter is built, rsp_timeout is tied to 0, and ACCESS waits indefinitely for PREADY.

## Test plan
- Write 0x0004 data 0x0000_0001, slave PREADY=1 immediately → PSEL=1 at T+1, PENABLE=1 at T+2, rsp_valid=1 at T+3 with rsp_err=0, rsp_rdata=0.
- Read 0x0010, slave inserts 2 wait states and then returns 0x0000_0005 → rsp_valid at T+5, rsp_rdata=0x0000_0005, PADDR stable throughout.
- Read 0x00FC, slave returns PREADY=1 with PSLVERR=1 → rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- With APB_INT_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave holds PREADY=0 → after 16 ACCESS cycles, PSEL=0 and rsp_valid with rsp_err=1, rsp_timeout=1. Without the macro, the bench still sees ACCESS after 100 cycles.
- rsp_ready held low for 3 cycles after rsp_valid → response fields stable, cmd_ready=0, and a pending cmd_valid is not accepted until the cycle after the rsp_ready handshake.
- PRESET asserted mid-ACCESS → PSEL/PENABLE go to 0 asynchronously and cmd_ready=1 after release. The next command completes normally with no stale response.
